// File: rtl/trigger_arbiter.sv
// rtl/trigger_arbiter.sv - round-robin merge of M trigger requests into one sync-slotted trigger stream
// Grants at most one source per sync slot, spaced by a programmable holdoff, and tags each grant with {lost, id}.
module trigger_arbiter #(
  parameter int M   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           sync,
  input  logic           enable,
  input  logic [7:0]     gap,
  input  logic [M-1:0]   req,
  input  logic           clr_lost,
  output logic           trg_out,
  output logic [IDW:0]   data_out,
  output logic [M-1:0]   pending,
  output logic [7:0]     lost_cnt
);

  logic [M-1:0]   pend_q, pend_d;
  logic [M-1:0]   lost_q, lost_d;
  logic [7:0]     lost_cnt_q, lost_cnt_d;
  logic [7:0]     hold_q, hold_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           trg_q, trg_d;
  logic [IDW:0]   data_q, data_d;

  logic [M-1:0]   pend_vis;
  logic [M-1:0]   grant_mask;
  logic [M-1:0]   drop;
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] idx_w;
  logic           grant;
  logic [3:0]     drop_n;
  logic [8:0]     cnt_sum;

  // A request arriving on the decision edge itself is eligible for that edge.
  always_comb begin
    pend_vis  = pend_q | req;
    win_found = 1'b0;
    win_id    = '0;
    idx_w     = '0;
    for (int k = 0; k < M; k++) begin
      idx_w = IDW'((int'(ptr_q) + k) % M);
      if (!win_found && pend_vis[idx_w]) begin
        win_found = 1'b1;
        win_id    = idx_w;
      end
    end
    grant = sync && enable && (hold_q == 8'd0) && win_found;
  end

  always_comb begin
    grant_mask = '0;
    drop_n     = '0;
    for (int i = 0; i < M; i++) begin
      grant_mask[i] = grant && (win_id == IDW'(i));
    end
    drop = pend_q & req & ~grant_mask;
    for (int i = 0; i < M; i++) begin
      drop_n = drop_n + {3'b000, drop[i]};
    end
    cnt_sum = {1'b0, lost_cnt_q} + {5'b00000, drop_n};
  end

  always_comb begin
    pend_d     = '0;
    lost_d     = '0;
    lost_cnt_d = lost_cnt_q;
    trg_d      = trg_q;
    data_d     = data_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;

    if (enable) begin
      // A fresh request coinciding with its own grant survives as a new pending request.
      pend_d = (pend_vis & ~grant_mask) | (grant_mask & pend_q & req);
      lost_d = (lost_q | drop) & ~grant_mask;
      lost_cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end
    if (clr_lost) begin
      lost_cnt_d = 8'd0;
    end

    if (sync) begin
      if (grant) begin
        trg_d  = 1'b1;
        data_d = {lost_q[win_id], win_id};
        ptr_d  = IDW'((int'(win_id) + 1) % M);
        hold_d = gap;
      end else begin
        trg_d  = 1'b0;
        data_d = '0;
        if (hold_q != 8'd0) begin
          hold_d = hold_q - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= '0;
      lost_q     <= '0;
      lost_cnt_q <= '0;
      hold_q     <= '0;
      ptr_q      <= '0;
      trg_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      pend_q     <= pend_d;
      lost_q     <= lost_d;
      lost_cnt_q <= lost_cnt_d;
      hold_q     <= hold_d;
      ptr_q      <= ptr_d;
      trg_q      <= trg_d;
      data_q     <= data_d;
    end
  end

  assign trg_out  = trg_q;
  assign data_out = data_q;
  assign pending  = pend_q;
  assign lost_cnt = lost_cnt_q;

endmodule
